// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline buffer.
// Holds DEPTH {halt, data} entries in order and tracks a sticky HALT.
module pipe_stage_elastic #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 2,
    parameter bit PASSTHRU_READY = 1'b0,
    parameter bit ZERO_BUBBLE    = 1'b1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_halt,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_halt,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         halted
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    if (DEPTH < 1 || DEPTH > 8) begin : g_depth_chk
        $fatal(1, "pipe_stage_elastic: DEPTH must be 1..8");
    end

    logic [WIDTH:0]  mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            halted_q, halted_d;
    logic            push, pop;
    logic [WIDTH:0]  head;

    // Pointers wrap explicitly so non-power-of-2 depths work.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        in_ready = !halted_q && !flush &&
                   ((count_q < FULL) ||
                    (PASSTHRU_READY && (count_q == FULL) && out_ready));
        out_valid = (count_q != '0);
        head      = mem_q[rd_ptr_q];
        if (ZERO_BUBBLE && !out_valid) begin
            out_data = '0;
            out_halt = 1'b0;
        end else begin
            out_data = head[WIDTH-1:0];
            out_halt = head[WIDTH];
        end
        count  = count_q;
        halted = halted_q;
        push   = in_valid && in_ready;
        pop    = out_valid && out_ready;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        halted_d = halted_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_d = nxt(rd_ptr_q);
            end
            if (push) begin
                wr_ptr_d = nxt(wr_ptr_q);
                if (in_halt) begin
                    halted_d = 1'b1;
                end
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Payload storage needs no reset; push already excludes flush.
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem_q[wr_ptr_q] <= {in_halt, in_data};
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: three configurations share one stimulus,
// each checked against its own ordered-list reference model.
module tb_pipe_stage_elastic;

    logic CLK = 1'b0;
    logic RST;
    logic iv, ih, fl, ordy;
    logic [7:0] id;

    logic [2:0]      rdy, vld, oh, hlt;
    logic [2:0][7:0] dat;
    logic [2:0][3:0] cnt;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    function automatic int dep(int g);
        case (g)
            0:       return 2;
            1:       return 3;
            default: return 5;
        endcase
    endfunction

    function automatic bit pt(int g);
        return (g != 0);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = dep(g);
        logic [$clog2(D+1)-1:0] c;
        pipe_stage_elastic #(
            .WIDTH(8), .DEPTH(D),
            .PASSTHRU_READY(pt(g)), .ZERO_BUBBLE(1'b1)
        ) u (
            .CLK(CLK), .RST(RST),
            .in_valid(iv), .in_ready(rdy[g]),
            .in_data(id), .in_halt(ih), .flush(fl),
            .out_valid(vld[g]), .out_ready(ordy),
            .out_data(dat[g]), .out_halt(oh[g]),
            .count(c), .halted(hlt[g])
        );
        assign cnt[g] = 4'(c);
    end

    // Reference: per instance an ordered list of held {halt,data}.
    logic [8:0] mq [3][8];
    int         mn [3];
    bit         mh [3];
    bit         acc[3];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit h,
                        input bit f, input bit o, input bit r);
        bit er[3];
        @(negedge CLK);
        iv = v; id = d; ih = h; fl = f; ordy = o; RST = r;
        #1;
        for (int g = 0; g < 3; g++) begin
            er[g] = !mh[g] && !f &&
                    (mn[g] < dep(g) || (pt(g) && mn[g] == dep(g) && o));
            chk($sformatf("u%0d.in_ready", g), 32'(rdy[g]), 32'(er[g]));
            chk($sformatf("u%0d.out_valid", g), 32'(vld[g]),
                32'(mn[g] != 0));
            chk($sformatf("u%0d.out_data", g), 32'(dat[g]),
                mn[g] != 0 ? 32'(mq[g][0][7:0]) : 32'h0);
            chk($sformatf("u%0d.out_halt", g), 32'(oh[g]),
                mn[g] != 0 ? 32'(mq[g][0][8]) : 32'h0);
            chk($sformatf("u%0d.count", g), 32'(cnt[g]), 32'(mn[g]));
            chk($sformatf("u%0d.halted", g), 32'(hlt[g]), 32'(mh[g]));
        end
        @(posedge CLK);
        for (int g = 0; g < 3; g++) begin
            acc[g] = 1'b0;
            if (r || f) begin
                mn[g] = 0;
                mh[g] = 1'b0;
            end else begin
                if (o && mn[g] > 0) begin
                    for (int k = 0; k < 7; k++) mq[g][k] = mq[g][k+1];
                    mn[g]--;
                end
                if (v && er[g]) begin
                    mq[g][mn[g]] = {h, d};
                    mn[g]++;
                    acc[g] = 1'b1;
                    if (h) mh[g] = 1'b1;
                end
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) step(0, 8'h0, 0, 0, 1, 0);
    endtask

    initial begin
        int n;
        RST = 1'b1; iv = 0; id = 0; ih = 0; fl = 0; ordy = 0;
        for (int g = 0; g < 3; g++) begin
            mn[g] = 0; mh[g] = 1'b0;
        end
        repeat (2) @(posedge CLK);
        step(0, 8'h0, 0, 0, 0, 1);
        #2;
        chk("rst.count", 32'(cnt[0]), 32'h0);
        chk("rst.in_ready", 32'(rdy[0]), 32'h1);

        // Back-to-back stream with downstream always ready
        step(1, 8'h0A, 0, 0, 1, 0);
        step(1, 8'h0B, 0, 0, 1, 0);
        step(1, 8'h0C, 0, 0, 1, 0);
        #2;
        chk("t1.u0_data", 32'(dat[0]), 32'h0C);
        chk("t1.u0_count", 32'(cnt[0]), 32'h1);
        chk("t1.u0_ready", 32'(rdy[0]), 32'h1);
        drain();

        // Backpressure, then release
        step(1, 8'h11, 0, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0, 0);
        #2;
        chk("t2.u0_count", 32'(cnt[0]), 32'h2);
        chk("t2.u0_ready", 32'(rdy[0]), 32'h0);
        step(1, 8'h33, 0, 0, 0, 0);
        #2;
        chk("t2.u1_full_rdy", 32'(rdy[1]), 32'h0);
        step(1, 8'h33, 0, 0, 1, 0);
        #2;
        chk("t2.u0_head22", 32'(dat[0]), 32'h22);
        step(1, 8'h33, 0, 0, 1, 0);
        #2;
        chk("t2.u0_head33", 32'(dat[0]), 32'h33);
        drain();

        // Flush with concurrent push and pop
        step(1, 8'h01, 0, 0, 0, 0);
        step(1, 8'h02, 0, 0, 0, 0);
        step(1, 8'h03, 0, 1, 1, 0);
        #2;
        chk("t3.u1_count", 32'(cnt[1]), 32'h0);
        chk("t3.u1_valid", 32'(vld[1]), 32'h0);
        chk("t3.u1_data", 32'(dat[1]), 32'h0);
        step(1, 8'h04, 0, 0, 0, 0);
        #2;
        chk("t3.u1_head4", 32'(dat[1]), 32'h04);
        drain();

        // Sticky HALT
        step(1, 8'h05, 1, 0, 0, 0);
        step(1, 8'h06, 0, 0, 0, 0);
        #2;
        chk("t4.halted", 32'(hlt[0]), 32'h1);
        chk("t4.in_ready", 32'(rdy[0]), 32'h0);
        chk("t4.out_data", 32'(dat[0]), 32'h05);
        chk("t4.out_halt", 32'(oh[0]), 32'h1);
        drain();
        step(0, 8'h0, 0, 1, 0, 0);
        step(0, 8'h0, 0, 0, 0, 0);
        #2;
        chk("t4.unhalt", 32'(hlt[0]), 32'h0);
        chk("t4.ready_back", 32'(rdy[0]), 32'h1);

        // Streaming with toggling out_ready; wrap on the 3-deep instance
        n = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            step(1, 8'(8'h40 + n), 0, 0, (c % 2) == 0, 0);
            if (acc[1]) n++;
        end
        chk("t5.sent", 32'(n), 32'd10);
        drain();

        // Reset in the middle of a handshake
        step(1, 8'h71, 0, 0, 0, 0);
        step(1, 8'h72, 0, 0, 0, 0);
        step(1, 8'h73, 0, 0, 1, 1);
        #2;
        chk("t6.count", 32'(cnt[0]), 32'h0);
        chk("t6.valid", 32'(vld[0]), 32'h0);
        chk("t6.halted", 32'(hlt[0]), 32'h0);
        chk("t6.in_ready", 32'(rdy[0]), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised successor to the fixed-field inter-stage pipeline latches. The per-stage control and data fields are packed into one WIDTH-bit payload, held in a DEPTH-entry elastic buffer with a valid/ready handshake, and released downstream in order. It replaces the iHit-enable/flush latch with per-side backpressure, multi-entry skid buffering, optional ready pass-through, bubble zeroing and sticky HALT tracking. It is instanced between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
WIDTH, 32, payload width in bits (packed stage fields).
DEPTH, 2, number of entries (1..8); 1 = classic latch, 2 = full-throughput skid buffer.
PASSTHRU_READY, 0, 1 = in_ready also asserted when full and the head is popped in the same cycle.
ZERO_BUBBLE, 1, 1 = out_data/out_halt forced to 0 while out_valid=0.

Ports:
CLK  in  1  clock, all state updates on the rising edge
RST  in  1  synchronous, active-high reset
in_valid  in  1  upstream has a payload
in_ready  out  1  buffer accepts a payload this cycle
in_data  in  WIDTH  payload
in_halt  in  1  payload carries HALT
flush  in  1  discard all held entries (branch/jump resolve)
out_valid  out  1  head entry is valid
out_ready  in  1  downstream consumes the head this cycle
out_data  out  WIDTH  head payload
out_halt  out  1  head HALT flag
count  out  $clog2(DEPTH+1)  entries held
halted  out  1  sticky: a HALT entry has been accepted

Behaviour:
- Storage: circular buffer of DEPTH entries {halt, data}, with rd_ptr, wr_ptr and count. Pointers wrap at DEPTH, including non-power-of-2 values.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !halted & !flush & ((count < DEPTH) | (PASSTHRU_READY & count==DEPTH & out_ready)). It is combinational from state, flush and out_ready only, never from in_valid.
- out_valid = (count != 0). out_data and out_halt come from the head entry; when count==0 and ZERO_BUBBLE=1 both are 0.
- Latency: a payload pushed at edge N is visible at out_data after edge N (1 cycle) if the buffer was empty. No combinational in-to-out path.
- push & pop in the same cycle: count is unchanged, both pointers advance. This also applies when the buffer is full and PASSTHRU_READY=1.
- pop with count==0 cannot occur (out_valid=0). in_ready=0 blocks any push when full.
- flush: on the next edge count=0 and rd_ptr=wr_ptr=0, and halted is cleared. Any concurrent push or pop is ignored (flush has priority). in_ready is 0 during the flush cycle.
- halted: set at the edge where a push has in_halt=1. It then holds in_ready=0 until RST or flush. Entries already held continue to drain normally.
- RST (synchronous, highest priority, including over flush and any handshake in progress): count=0, pointers=0, halted=0. Consequently out_valid=0, out_data=0, out_halt=0, count=0 and in_ready=1 after the edge. Stored payload contents are don't-care.
- Entries are never reordered or duplicated. A payload is never lost unless flush or RST is asserted.
- Elaboration fails (assertion) if DEPTH<1 or DEPTH>8.

Test Plan:
1. DEPTH=2, out_ready=1, push 0xA, 0xB, 0xC on consecutive cycles -> out_data is 0xA, 0xB, 0xC one cycle after each push; count stays 1; in_ready=1 throughout.
2. DEPTH=2, out_ready=0, push 0x11, 0x22 then offer 0x33 -> count=2, in_ready=0, 0x33 held upstream. Raise out_ready -> drains 0x11, 0x22, 0x33 in order. With PASSTHRU_READY=1, 0x33 is accepted in the same cycle 0x11 pops.
3. DEPTH=3, hold 0x1, 0x2 and assert flush together with in_valid=1 (0x3) and out_ready=1 -> next cycle count=0, out_valid=0, out_data=0; 0x3 is not stored; the following push of 0x4 emerges first.
4. Push 0x5 with in_halt=1, then offer 0x6 -> halted=1, in_ready=0, 0x6 never accepted; 0x5 emerges with out_halt=1. A subsequent flush clears halted and in_ready returns to 1.
5. DEPTH=3, streaming 10 payloads with out_ready toggling 1,0,1,0 -> output sequence equals input sequence with no loss; pointers wrap past 2 correctly; count never exceeds 3.
6. RST asserted mid-stream with count=2 and in_valid=out_ready=1 -> after the edge out_valid=0, count=0, halted=0, in_ready=1; no payload is emitted on the reset cycle's edge.
